// File: rtl/tick_gen_pkg.sv
// Shared types and reset defaults for the multi-channel tick generator.
package tick_gen_pkg;

    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Reset-time configuration; P=5/H=1 reproduces the legacy divide-by-five tick.
    localparam int TICK_DEF_PERIOD = 5;
    localparam int TICK_DEF_HIGH   = 1;

endpackage

// File: rtl/tick_gen_channel.sv
// One tick channel: active/pending configuration, counter and IDLE/RUN FSM.
// Optional feature macro: TICK_GEN_PHASE_EN (adds a start phase to the config).
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = TICK_DEF_PERIOD,
    parameter int DEF_HIGH   = TICK_DEF_HIGH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_mode,
`ifdef TICK_GEN_PHASE_EN
    input  logic [CNT_W-1:0] cfg_phase,
`endif
    input  logic             start,
    input  logic             stop,
    output logic             out,
    output logic             busy,
    output logic             done
);

    // P=0 is treated as P=1 so the counter always has a legal terminal value.
    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        return (p == {CNT_W{1'b0}}) ? CNT_W'(1) : p;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] act_period_r, act_period_s;
    logic [CNT_W-1:0] act_high_r, act_high_s;
    mode_t            act_mode_r, act_mode_s;
    logic [CNT_W-1:0] pend_period_r, pend_period_s;
    logic [CNT_W-1:0] pend_high_r, pend_high_s;
    mode_t            pend_mode_r, pend_mode_s;
    logic             pend_flag_r, pend_flag_s;
    logic             out_r, out_s;
    logic             done_r, done_s;

    // Configuration about to take effect (pending if any, else the active one).
    logic [CNT_W-1:0] new_period_s;
    logic [CNT_W-1:0] new_high_s;
    mode_t            new_mode_s;
    logic [CNT_W-1:0] load_s;
    logic [CNT_W-1:0] pe_s;
    logic             at_end_s;
    logic             apply_s;

`ifdef TICK_GEN_PHASE_EN
    logic [CNT_W-1:0] act_phase_r, act_phase_s;
    logic [CNT_W-1:0] pend_phase_r, pend_phase_s;
    logic [CNT_W-1:0] new_phase_s;
`endif

    // Next-state logic: config merge, counter, FSM and registered-output values.
    always_comb begin
        // A write this cycle is visible to a same-cycle start or wrap.
        pend_period_s = cfg_we ? cfg_period : pend_period_r;
        pend_high_s   = cfg_we ? cfg_high   : pend_high_r;
        pend_mode_s   = cfg_we ? mode_t'(cfg_mode) : pend_mode_r;
        pend_flag_s   = cfg_we | pend_flag_r;
`ifdef TICK_GEN_PHASE_EN
        pend_phase_s  = cfg_we ? cfg_phase : pend_phase_r;
`endif

        new_period_s = pend_flag_s ? pend_period_s : act_period_r;
        new_high_s   = pend_flag_s ? pend_high_s   : act_high_r;
        new_mode_s   = pend_flag_s ? pend_mode_s   : act_mode_r;
`ifdef TICK_GEN_PHASE_EN
        new_phase_s  = pend_flag_s ? pend_phase_s  : act_phase_r;
        // Out-of-range phase falls back to the start of the period.
        load_s = (new_phase_s < eff_period(new_period_s)) ? new_phase_s : {CNT_W{1'b0}};
`else
        load_s = {CNT_W{1'b0}};
`endif

        pe_s     = eff_period(act_period_r);
        at_end_s = (cnt_r >= (pe_s - CNT_W'(1)));

        state_s      = state_r;
        cnt_s        = cnt_r;
        act_period_s = act_period_r;
        act_high_s   = act_high_r;
        act_mode_s   = act_mode_r;
`ifdef TICK_GEN_PHASE_EN
        act_phase_s  = act_phase_r;
`endif
        done_s  = 1'b0;
        apply_s = 1'b0;

        if (stop) begin
            // Stop dominates start and never produces a done pulse.
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else if (start) begin
            state_s = ST_RUN;
            apply_s = 1'b1;
            cnt_s   = load_s;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (at_end_s) begin
                        if (act_mode_r == MODE_ONESHOT) begin
                            state_s = ST_IDLE;
                            cnt_s   = {CNT_W{1'b0}};
                            done_s  = 1'b1;
                        end else if (pend_flag_s) begin
                            apply_s = 1'b1;
                            cnt_s   = load_s;
                        end else begin
                            cnt_s = {CNT_W{1'b0}};
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    cnt_s = {CNT_W{1'b0}};
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end

        if (apply_s) begin
            act_period_s = new_period_s;
            act_high_s   = new_high_s;
            act_mode_s   = new_mode_s;
`ifdef TICK_GEN_PHASE_EN
            act_phase_s  = new_phase_s;
`endif
            pend_flag_s  = 1'b0;
        end else begin
            pend_flag_s  = pend_flag_s;
        end

        // Output computed from next-cycle values so it can be registered.
        out_s = (state_s == ST_RUN) && (cnt_s < act_high_s);
    end

    // State, config and output registers with synchronous reset to defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            act_period_r  <= CNT_W'(DEF_PERIOD);
            act_high_r    <= CNT_W'(DEF_HIGH);
            act_mode_r    <= MODE_CONT;
            pend_period_r <= CNT_W'(DEF_PERIOD);
            pend_high_r   <= CNT_W'(DEF_HIGH);
            pend_mode_r   <= MODE_CONT;
            pend_flag_r   <= 1'b0;
            out_r         <= 1'b0;
            done_r        <= 1'b0;
`ifdef TICK_GEN_PHASE_EN
            act_phase_r   <= {CNT_W{1'b0}};
            pend_phase_r  <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            act_period_r  <= act_period_s;
            act_high_r    <= act_high_s;
            act_mode_r    <= act_mode_s;
            pend_period_r <= pend_period_s;
            pend_high_r   <= pend_high_s;
            pend_mode_r   <= pend_mode_s;
            pend_flag_r   <= pend_flag_s;
            out_r         <= out_s;
            done_r        <= done_s;
`ifdef TICK_GEN_PHASE_EN
            act_phase_r   <= act_phase_s;
            pend_phase_r  <= pend_phase_s;
`endif
        end
    end

    assign out  = out_r;
    assign busy = (state_r == ST_RUN);
    assign done = done_r;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable periodic pulse generator (top level).
// Optional feature macro: TICK_GEN_PHASE_EN (adds cfg_phase input).
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = TICK_DEF_PERIOD,
    parameter int DEF_HIGH   = TICK_DEF_HIGH,
    localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_mode,
`ifdef TICK_GEN_PHASE_EN
    input  logic [CNT_W-1:0] cfg_phase,
`endif
    input  logic [CH-1:0]    start,
    input  logic [CH-1:0]    stop,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    done
);

    logic [CH-1:0] ch_we_s;

    // Decode the channel select into per-channel write strobes; out-of-range selects hit nothing.
    always_comb begin
        ch_we_s = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            if (cfg_we && (32'(cfg_ch) == 32'(i))) begin
                ch_we_s[i] = 1'b1;
            end else begin
                ch_we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        tick_gen_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cfg_we     (ch_we_s[g]),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .cfg_mode   (cfg_mode),
`ifdef TICK_GEN_PHASE_EN
            .cfg_phase  (cfg_phase),
`endif
            .start      (start[g]),
            .stop       (stop[g]),
            .out        (out[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: vector table plus hand-written corner sequences.
// Phase checks are compiled when TICK_GEN_PHASE_EN is defined.
module tb_tick_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic        cfg_mode;
`ifdef TICK_GEN_PHASE_EN
    logic [15:0] cfg_phase;
`endif
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  out;
    logic [3:0]  busy;
    logic [3:0]  done;

    int checks   = 0;
    int failures = 0;

    tick_generator #(.CH(4), .CNT_W(16), .DEF_PERIOD(5), .DEF_HIGH(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_mode   (cfg_mode),
`ifdef TICK_GEN_PHASE_EN
        .cfg_phase  (cfg_phase),
`endif
        .start      (start),
        .stop       (stop),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] p;
        logic [15:0] h;
        logic        m;
        logic [3:0]  st;
        logic [3:0]  sp;
        logic [3:0]  eo;
        logic [3:0]  eb;
        logic [3:0]  ed;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic we, input logic [1:0] ch,
                                input logic [15:0] p, input logic [15:0] h, input logic m,
                                input logic [3:0] st, input logic [3:0] sp,
                                input logic [3:0] eo, input logic [3:0] eb, input logic [3:0] ed,
                                input string name);
        vec_t v;
        v.rst = rst; v.we = we; v.ch = ch; v.p = p; v.h = h; v.m = m;
        v.st = st; v.sp = sp; v.eo = eo; v.eb = eb; v.ed = ed; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic [3:0] eo, input logic [3:0] eb,
                                 input logic [3:0] ed, input string name);
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, eo, eb, ed, name);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        reset = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_period = 16'd0;
        cfg_high = 16'd0; cfg_mode = 1'b0; start = 4'b0000; stop = 4'b0000;
`ifdef TICK_GEN_PHASE_EN
        cfg_phase = 16'd0;
`endif
    endtask

    // Apply at the falling edge, let one rising edge pass, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_cnt;
        int high_cnt;
        bit seen;

        drive_idle();
        reset = 1'b1;

        // Reset and default start: 1-in-5 pulse on cycles 1, 6, 11.
        add(1'b1, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset");
        idle(4'b0000, 4'b0000, 4'b0000, "reset_idle");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, "s0_pulse1");
        for (int i = 0; i < 4; i++) idle(4'b0000, 4'b0001, 4'b0000, "s0_low_a");
        idle(4'b0001, 4'b0001, 4'b0000, "s0_pulse6");
        for (int i = 0; i < 4; i++) idle(4'b0000, 4'b0001, 4'b0000, "s0_low_b");
        idle(4'b0001, 4'b0001, 4'b0000, "s0_pulse11");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "s0_stop");

        // Channel 1 one-shot P=4 H=2.
        add(1'b0, 1'b1, 2'd1, 16'd4, 16'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "c1_cfg");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, "c1_os0");
        idle(4'b0010, 4'b0010, 4'b0000, "c1_os1");
        idle(4'b0000, 4'b0010, 4'b0000, "c1_os2");
        idle(4'b0000, 4'b0010, 4'b0000, "c1_os3");
        idle(4'b0000, 4'b0000, 4'b0010, "c1_done");
        idle(4'b0000, 4'b0000, 4'b0000, "c1_idle");

        // Channel 0 reconfigured to P=8 mid-period; current period still 5.
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, "c0_start");
        idle(4'b0000, 4'b0001, 4'b0000, "c0_cnt1");
        add(1'b0, 1'b1, 2'd0, 16'd8, 16'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "c0_cfg_p8");
        idle(4'b0000, 4'b0001, 4'b0000, "c0_cnt3");
        idle(4'b0000, 4'b0001, 4'b0000, "c0_cnt4");
        idle(4'b0001, 4'b0001, 4'b0000, "c0_wrap5");
        for (int i = 0; i < 7; i++) idle(4'b0000, 4'b0001, 4'b0000, "c0_p8_low");
        idle(4'b0001, 4'b0001, 4'b0000, "c0_period8");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "c0_stop");

        // Channel 2: stop beats start, then P=0 H=1 gives constant high.
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, "c2_start");
        idle(4'b0000, 4'b0100, 4'b0000, "c2_cnt1");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "c2_stopwins");
        idle(4'b0000, 4'b0000, 4'b0000, "c2_nodone");
        add(1'b0, 1'b1, 2'd2, 16'd0, 16'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "c2_cfg_p0");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, "c2_p0_start");
        for (int i = 0; i < 3; i++) idle(4'b0100, 4'b0100, 4'b0000, "c2_p0_high");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "c2_stop");

        // Channel 3: write and start in the same cycle uses the new P=3 H=2 one-shot.
        add(1'b0, 1'b1, 2'd3, 16'd3, 16'd2, 1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, "c3_same_cyc");
        idle(4'b1000, 4'b1000, 4'b0000, "c3_cnt1");
        idle(4'b0000, 4'b1000, 4'b0000, "c3_cnt2");
        idle(4'b0000, 4'b0000, 4'b1000, "c3_done");

        // All channels running, reset mid-run, then defaults restored everywhere.
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, "all_start");
        idle(4'b1110, 4'b1111, 4'b0000, "all_cnt1");
        add(1'b1, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mid_reset");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, "def_start");
        for (int i = 0; i < 4; i++) idle(4'b0000, 4'b1111, 4'b0000, "def_low");
        idle(4'b1111, 4'b1111, 4'b0000, "def_period5");
        add(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "all_stop");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            cfg_we     = vecs[i].we;
            cfg_ch     = vecs[i].ch;
            cfg_period = vecs[i].p;
            cfg_high   = vecs[i].h;
            cfg_mode   = vecs[i].m;
            start      = vecs[i].st;
            stop       = vecs[i].sp;
            step();
            check($sformatf("%s[%0d].out", vecs[i].name, i), 32'(out), 32'(vecs[i].eo));
            check($sformatf("%s[%0d].busy", vecs[i].name, i), 32'(busy), 32'(vecs[i].eb));
            check($sformatf("%s[%0d].done", vecs[i].name, i), 32'(done), 32'(vecs[i].ed));
        end

        // One-shot P=10 H=0 on channel 1: bounded wait for done, count busy and high cycles.
        @(negedge clk);
        drive_idle();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd10; cfg_high = 16'd0; cfg_mode = 1'b1;
        @(negedge clk);
        drive_idle();
        start = 4'b0010;
        step();
        @(negedge clk);
        drive_idle();
        #2;
        busy_cnt = 0;
        high_cnt = 0;
        seen     = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done[1]) begin
                seen = 1'b1;
                break;
            end
            if (busy[1]) busy_cnt++;
            if (out[1]) high_cnt++;
            step();
        end
        check("os10_done_seen", 32'(seen), 32'd1);
        check("os10_busy_cycles", 32'(busy_cnt), 32'd10);
        check("os10_h0_high_cycles", 32'(high_cnt), 32'd0);
        check("os10_busy_at_done", 32'(busy[1]), 32'd0);
        step();
        check("os10_done_width", 32'(done[1]), 32'd0);

`ifdef TICK_GEN_PHASE_EN
        // Phase 3 on P=5 H=1: first pulse two cycles after busy rises.
        @(negedge clk);
        drive_idle();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd5; cfg_high = 16'd1; cfg_phase = 16'd3;
        start = 4'b0001;
        step();
        check("ph3_busy", 32'(busy[0]), 32'd1);
        check("ph3_out_c1", 32'(out[0]), 32'd0);
        @(negedge clk);
        drive_idle();
        step();
        check("ph3_out_c2", 32'(out[0]), 32'd0);
        step();
        check("ph3_out_c3", 32'(out[0]), 32'd1);
        // Phase 7 exceeds the period, so the channel starts from 0.
        @(negedge clk);
        drive_idle();
        stop = 4'b0001;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd5; cfg_high = 16'd1; cfg_phase = 16'd7;
        step();
        @(negedge clk);
        drive_idle();
        start = 4'b0001;
        step();
        check("ph7_out_c1", 32'(out[0]), 32'd1);
        @(negedge clk);
        drive_idle();
        step();
        check("ph7_out_c2", 32'(out[0]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
# tick_generator

Multi-channel programmable periodic pulse generator, successor to the fixed divide-by-five tick block. Each of CH independent channels produces a pulse train with run-time programmable period and high time, in continuous or one-shot mode. It sits beside the timer/strobe logic and drives enables, sample strobes and PWM-style outputs.

## Interface
- CH, default 4: number of independent channels (≥1).
- CNT_W, default 16: counter/period width in bits.
- DEF_PERIOD, default 5: period loaded into every channel at reset.
- DEF_HIGH, default 1: high time loaded into every channel at reset.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for the channel configuration.
- cfg_ch  in  max(1,$clog2(CH))  channel targeted by the write; values ≥ CH are ignored.
- cfg_period  in  CNT_W  period P in cycles.
- cfg_high  in  CNT_W  high time H in cycles.
- cfg_mode  in  1  0 = continuous, 1 = one-shot.
- start  in  CH  per-channel start/restart request.
- stop  in  CH  per-channel stop request.
- out  out  CH  pulse outputs.
- busy  out  CH  channel running.
- done  out  CH  one-cycle pulse at the end of a one-shot period.

## Operation
- Per channel: active config (P, H, mode), pending config plus pending flag, counter cnt, and state IDLE/RUN.
- Reset: all channels IDLE, cnt=0, active and pending config = DEF_PERIOD/DEF_HIGH/continuous, pending flag clear; out, busy and done are all 0.
- cfg_we writes the pending config and sets the pending flag. Pending config becomes active on one of two events: start (any state), or the wrap of cnt from P-1 to 0 in RUN. A write in IDLE becomes active at the next start.
- Effective period Pe = max(P,1). P=0 behaves as P=1.
- IDLE -> RUN on start: cnt=0.
- RUN: cnt increments each cycle. At cnt==Pe-1:
  - Continuous: cnt wraps to 0.
  - One-shot: go to IDLE, cnt=0, done=1 for the next cycle.
- start while RUN restarts: cnt=0 and pending config applied.
- stop: go to IDLE, cnt=0, no done pulse. If start and stop arrive together, stop wins.
- out = RUN && (cnt < H). H=0 gives a constant 0. H ≥ Pe gives a constant 1 while running. out is 0 in IDLE.
- busy = (state == RUN).
- Comparisons are unsigned and CNT_W wide. The counter never exceeds Pe-1.

## Timing
- All outputs come from registers or from register-only logic. There is no combinational path from inputs to outputs.
- If start is sampled at edge N, then busy=1 and cnt=0 from cycle N+1, with out=(H>0) in that cycle.
- Continuous mode: out repeats with exactly Pe cycles per period. P=5, H=1 gives a 1-in-5 pulse, identical to the legacy tick.
- One-shot mode: busy stays high for exactly Pe cycles. done is high in the first IDLE cycle.
- stop sampled at edge N: busy=out=0 from cycle N+1.
- A config write at edge N is usable by a start at edge N+1 or later. A same-cycle cfg_we and start on the same channel uses the newly written value.
- reset in mid-operation overrides everything on the next edge.

## Configuration
- TICK_GEN_PHASE_EN defined:
  - Adds input cfg_phase [CNT_W] to the configuration set.
  - start and period-boundary config activation load cnt = phase when phase < Pe, otherwise 0.
  - Reset phase = 0.
- Undefined: the port is absent and cnt always loads 0.

## Structure
- tick_gen_pkg: mode type (MODE_CONT, MODE_ONESHOT), channel state type (ST_IDLE, ST_RUN), and the default-period and default-high constants.
- Sub-module tick_gen_channel: one channel's config registers, counter and FSM. It is instantiated CH times in a generate loop, and the top level decodes cfg_ch into per-channel write enables.

## Test plan
- Reset, then start[0] with defaults -> out[0] high 1 cycle in every 5 (cycles 1, 6, 11 after start); busy[0]=1.
- Write ch1 P=4, H=2, one-shot, then start[1] -> out[1]=1,1,0,0; busy 4 cycles; done[1] pulses once in the following cycle; channel idle afterwards.
- Write ch0 P=8 while running at P=5 -> the current period completes at 5 cycles, and every later period is 8 cycles.
- start[2] and stop[2] in the same cycle while running -> channel goes idle, out=0, no done pulse. Then P=0, H=1 -> out constantly 1 while running.
- All CH channels started with different periods, and reset asserted mid-run -> all outputs 0 on the next cycle and configs return to 5/1/continuous.
- With TICK_GEN_PHASE_EN: P=5, H=1, phase=3, then start -> first out pulse 2 cycles after busy rises; phase=7 -> behaves as phase 0.
